multi_dataflow_mac_mdc_tcdm_responder: RTL and testbench

//  Memory-side responder for the TCDM protocol used by the streamer.

---
 rtl/multi_dataflow_mac_mdc_package.sv | 40 ++++
 rtl/hwpe_stream_intf_tcdm.sv | 17 +
 rtl/multi_dataflow_mac_mdc_rr_arbiter.sv | 71 +++++++
 rtl/multi_dataflow_mac_mdc_tcdm_responder.sv | 119 +++++++++++
 tb/tb_multi_dataflow_mac_mdc_tcdm_responder.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/multi_dataflow_mac_mdc_package.sv
// Shared types and helpers for the TCDM responder.
//  - TCDM_DW / TCDM_BEW : data width and byte-enable width of a TCDM word
//  - tcdm_rsp_t         : one-deep response stage (valid, target port, data)
//  - lfsr_step          : 16-bit Galois LFSR, taps 0xB400
//  - be_merge           : byte-enable merge of new data over an old word
package multi_dataflow_mac_mdc_package;

    localparam int TCDM_DW  = 32;
    localparam int TCDM_BEW = 4;
    localparam int NP_MAX   = 8;
    localparam int PORT_W   = 3;   // wide enough for NP_MAX ports

    typedef struct packed {
        logic              valid;
        logic [PORT_W-1:0] port;
        logic [TCDM_DW-1:0] data;
    } tcdm_rsp_t;

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {1'b0, s[15:1]} ^ (s[0] ? 16'hB400 : 16'h0000);
    endfunction

    function automatic logic [TCDM_DW-1:0] be_merge(
        input logic [TCDM_DW-1:0]  old_w,
        input logic [TCDM_DW-1:0]  new_w,
        input logic [TCDM_BEW-1:0] be
    );
        logic [TCDM_DW-1:0] r;
        r = old_w;
        for (int b = 0; b < TCDM_BEW; b++) begin
            if (be[b]) begin
                r[8*b +: 8] = new_w[8*b +: 8];
            end else begin
                r[8*b +: 8] = old_w[8*b +: 8];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/hwpe_stream_intf_tcdm.sv
// TCDM request/response bundle between a streamer master and a memory slave.
//  req/add/wen/be/data : master -> slave request (held until gnt)
//  gnt                 : slave -> master, same-cycle grant
//  r_data/r_valid      : slave -> master response, one cycle after grant
interface hwpe_stream_intf_tcdm;
    logic        req;
    logic        gnt;
    logic [31:0] add;
    logic        wen;
    logic [3:0]  be;
    logic [31:0] data;
    logic [31:0] r_data;
    logic        r_valid;

    modport master (output req, add, wen, be, data, input gnt, r_data, r_valid);
    modport slave  (input req, add, wen, be, data, output gnt, r_data, r_valid);
endinterface

// File: rtl/multi_dataflow_mac_mdc_rr_arbiter.sv
// Round-robin arbiter: NP requests -> one-hot grant, plus its priority pointer.
//  req_i       : request vector
//  en_i        : 0 suppresses every grant (stall, clear, reset)
//  gnt_o       : one-hot grant (all zero when nothing granted)
//  gnt_valid_o : a grant was issued this cycle
//  gnt_idx_o   : index of the granted port
module multi_dataflow_mac_mdc_rr_arbiter #(
    parameter int NP = 4,
    parameter int PW = (NP > 1) ? $clog2(NP) : 1
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          clear_i,
    input  logic          en_i,
    input  logic [NP-1:0] req_i,
    output logic [NP-1:0] gnt_o,
    output logic          gnt_valid_o,
    output logic [PW-1:0] gnt_idx_o
);

    logic [PW-1:0] ptr_r;
    logic [PW:0]   cand_s;
    logic [PW-1:0] cand_idx_s;
    logic          hit_s;
    logic          found_s;
    logic [PW-1:0] idx_s;

    // Scan from the pointer upward (modulo NP) and take the first requester.
    always_comb begin
        cand_s     = '0;
        cand_idx_s = '0;
        hit_s      = 1'b0;
        found_s    = 1'b0;
        idx_s      = '0;
        for (int i = 0; i < NP; i++) begin
            cand_s = {1'b0, ptr_r} + (PW+1)'(i);
            if (cand_s >= (PW+1)'(NP)) begin
                cand_s = cand_s - (PW+1)'(NP);
            end else begin
                cand_s = cand_s;
            end
            cand_idx_s = cand_s[PW-1:0];
            hit_s      = en_i && req_i[cand_idx_s] && !found_s;
            idx_s      = hit_s ? cand_idx_s : idx_s;
            found_s    = found_s | hit_s;
        end
    end

    // One-hot decode of the winning index.
    always_comb begin
        gnt_o = '0;
        for (int i = 0; i < NP; i++) begin
            gnt_o[i] = found_s && (idx_s == PW'(i));
        end
    end

    assign gnt_valid_o = found_s;
    assign gnt_idx_o   = idx_s;

    // Pointer moves just past the last winner; held when nothing is granted.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_r <= '0;
        end else if (clear_i) begin
            ptr_r <= '0;
        end else if (found_s) begin
            ptr_r <= (idx_s == PW'(NP-1)) ? '0 : idx_s + PW'(1);
        end
    end

endmodule

// File: rtl/multi_dataflow_mac_mdc_tcdm_responder.sv
// Memory-side TCDM responder: NP slave ports share one word-addressed memory.
//  clk_i, rst_ni : clock, async active-low reset
//  clear_i       : sync soft clear of arbiter, LFSR and response stage
//  tcdm[NP-1:0]  : TCDM slave ports (combinational gnt, registered response)
//  busy_o        : a response is pending in the response stage
// Optional LFSR stalls withhold every grant on roughly 1/4 of cycles.
module multi_dataflow_mac_mdc_tcdm_responder
    import multi_dataflow_mac_mdc_package::*;
#(
    parameter int          NP        = 4,
    parameter int          DEPTH     = 1024,
    parameter int          STALL_EN  = 0,
    parameter logic [15:0] STALL_MSK = 16'h0003,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 clear_i,
    hwpe_stream_intf_tcdm.slave  tcdm [NP-1:0],
    output logic                 busy_o
);

    localparam int PW = (NP > 1) ? $clog2(NP) : 1;
    localparam int AW = $clog2(DEPTH);

    logic [NP-1:0]       req_s;
    logic [NP-1:0]       wen_s;
    logic [31:0]         add_s  [NP];
    logic [31:0]         data_s [NP];
    logic [3:0]          be_s   [NP];
    logic [NP-1:0]       gnt_s;
    logic [NP-1:0]       r_valid_s;
    logic                gnt_valid_s;
    logic [PW-1:0]       gnt_idx_s;
    logic                en_s;
    logic                stall_s;
    logic [15:0]         lfsr_r;
    logic [31:0]         sel_add_s;
    logic [31:0]         sel_data_s;
    logic [3:0]          sel_be_s;
    logic                sel_wen_s;
    logic [AW-1:0]       idx_s;
    logic                unused_s;
    logic [TCDM_DW-1:0]  mem_r [DEPTH];
    tcdm_rsp_t           rsp_r;

    for (genvar g = 0; g < NP; g++) begin : g_port
        assign req_s[g]  = tcdm[g].req;
        assign wen_s[g]  = tcdm[g].wen;
        assign add_s[g]  = tcdm[g].add;
        assign data_s[g] = tcdm[g].data;
        assign be_s[g]   = tcdm[g].be;
        assign tcdm[g].gnt = gnt_s[g];
        // The pending response is hidden during clear so a dropped read never shows.
        assign r_valid_s[g]   = rsp_r.valid && !clear_i && (rsp_r.port == PORT_W'(g));
        assign tcdm[g].r_valid = r_valid_s[g];
        assign tcdm[g].r_data  = r_valid_s[g] ? rsp_r.data : 32'h0000_0000;
    end

    assign stall_s = (STALL_EN != 0) && ((lfsr_r & STALL_MSK) == 16'h0000);
    // rst_ni is included so gnt drops immediately on an asynchronous reset.
    assign en_s    = rst_ni && !clear_i && !stall_s;

    multi_dataflow_mac_mdc_rr_arbiter #(
        .NP (NP),
        .PW (PW)
    ) i_arb (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .clear_i     (clear_i),
        .en_i        (en_s),
        .req_i       (req_s),
        .gnt_o       (gnt_s),
        .gnt_valid_o (gnt_valid_s),
        .gnt_idx_o   (gnt_idx_s)
    );

    assign sel_add_s  = add_s[gnt_idx_s];
    assign sel_data_s = data_s[gnt_idx_s];
    assign sel_be_s   = be_s[gnt_idx_s];
    assign sel_wen_s  = wen_s[gnt_idx_s];
    assign idx_s      = sel_add_s[2 +: AW];
    // Byte offset and address bits above the memory size are deliberately dropped.
    assign unused_s   = ^(sel_add_s & ~(32'(DEPTH-1) << 2));

    // LFSR free-runs every cycle, independent of requests.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lfsr_r <= LFSR_SEED;
        end else if (clear_i) begin
            lfsr_r <= LFSR_SEED;
        end else begin
            lfsr_r <= lfsr_step(lfsr_r);
        end
    end

    // Memory write at the grant edge; contents survive reset and clear.
    always_ff @(posedge clk_i) begin
        if (gnt_valid_s && !sel_wen_s) begin
            mem_r[idx_s] <= be_merge(mem_r[idx_s], sel_data_s, sel_be_s);
        end
    end

    // Response stage: one-cycle r_valid for every grant, read data or zero.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rsp_r <= '0;
        end else if (clear_i) begin
            rsp_r <= '0;
        end else begin
            rsp_r.valid <= gnt_valid_s;
            rsp_r.port  <= gnt_valid_s ? PORT_W'(gnt_idx_s) : '0;
            rsp_r.data  <= (gnt_valid_s && sel_wen_s) ? mem_r[idx_s] : 32'h0000_0000;
        end
    end

    assign busy_o = rsp_r.valid && !clear_i;

endmodule

// File: tb/tb_multi_dataflow_mac_mdc_tcdm_responder.sv
module tb_multi_dataflow_mac_mdc_tcdm_responder;

    logic clk = 1'b0;
    logic rst_ni;
    logic clear_a;

    logic [3:0]       req_a, wen_a, gnt_a, rv_a;
    logic [3:0][31:0] add_a, data_a, rd_a;
    logic [3:0][3:0]  be_a;
    logic             busy_a;

    logic [3:0]       req_b, wen_b, gnt_b, rv_b;
    logic [3:0][31:0] add_b, data_b, rd_b;
    logic [3:0][3:0]  be_b;
    logic             busy_b;

    int checks = 0;
    int errors = 0;
    int gnt_viol = 0;
    int rv_viol = 0;
    int stall_cnt = 0;
    logic [3:0] prev_gnt_b = 4'b0000;

    hwpe_stream_intf_tcdm tcdm_a [3:0] ();
    hwpe_stream_intf_tcdm tcdm_b [3:0] ();

    for (genvar g = 0; g < 4; g++) begin : g_bind
        assign tcdm_a[g].req  = req_a[g];
        assign tcdm_a[g].wen  = wen_a[g];
        assign tcdm_a[g].add  = add_a[g];
        assign tcdm_a[g].data = data_a[g];
        assign tcdm_a[g].be   = be_a[g];
        assign gnt_a[g] = tcdm_a[g].gnt;
        assign rv_a[g]  = tcdm_a[g].r_valid;
        assign rd_a[g]  = tcdm_a[g].r_data;
        assign tcdm_b[g].req  = req_b[g];
        assign tcdm_b[g].wen  = wen_b[g];
        assign tcdm_b[g].add  = add_b[g];
        assign tcdm_b[g].data = data_b[g];
        assign tcdm_b[g].be   = be_b[g];
        assign gnt_b[g] = tcdm_b[g].gnt;
        assign rv_b[g]  = tcdm_b[g].r_valid;
        assign rd_b[g]  = tcdm_b[g].r_data;
    end

    multi_dataflow_mac_mdc_tcdm_responder #(
        .NP(4), .DEPTH(1024), .STALL_EN(0)
    ) dut_a (
        .clk_i(clk), .rst_ni(rst_ni), .clear_i(clear_a), .tcdm(tcdm_a), .busy_o(busy_a)
    );

    multi_dataflow_mac_mdc_tcdm_responder #(
        .NP(4), .DEPTH(1024), .STALL_EN(1)
    ) dut_b (
        .clk_i(clk), .rst_ni(rst_ni), .clear_i(1'b0), .tcdm(tcdm_b), .busy_o(busy_b)
    );

    always #5 clk = ~clk;

    // Protocol monitor on the stalling instance, sampled mid-cycle.
    always @(negedge clk) begin
        if ((gnt_b & ~req_b) != 4'b0000) gnt_viol <= gnt_viol + 1;
        if (rv_b != prev_gnt_b) rv_viol <= rv_viol + 1;
        if (req_b != 4'b0000 && gnt_b == 4'b0000) stall_cnt <= stall_cnt + 1;
        prev_gnt_b <= gnt_b;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t required < 200000", $time);
        $fatal(1);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_a;
        req_a = 4'b0000; wen_a = 4'b0000; add_a = '0; data_a = '0; be_a = '0;
    endtask

    task automatic test_reset;
        rst_ni = 1'b0;
        req_a = 4'b0001;
        #1;
        checks++; if (gnt_a !== 4'b0000) begin errors++; $display("FAIL reset_gnt got %b want 0000", gnt_a); end
        checks++; if (rv_a !== 4'b0000) begin errors++; $display("FAIL reset_rvalid got %b want 0000", rv_a); end
        checks++; if (busy_a !== 1'b0 || busy_b !== 1'b0) begin errors++; $display("FAIL reset_busy got %b/%b want 0/0", busy_a, busy_b); end
        tick; tick;
        req_a = 4'b0000;
        rst_ni = 1'b1;
        tick;
        checks++; if (rv_a !== 4'b0000 || busy_a !== 1'b0) begin errors++; $display("FAIL post_reset_idle got rv %b busy %b want 0000 0", rv_a, busy_a); end
    endtask

    task automatic test_write_read;
        req_a[0] = 1'b1; add_a[0] = 32'h10; wen_a[0] = 1'b0; be_a[0] = 4'hF; data_a[0] = 32'hDEADBEEF;
        #3;
        checks++; if (gnt_a !== 4'b0001) begin errors++; $display("FAIL wr_gnt got %b want 0001", gnt_a); end
        tick;
        checks++; if (rv_a !== 4'b0001 || rd_a[0] !== 32'h0) begin errors++; $display("FAIL wr_rsp got rv %b data %h want 0001 0", rv_a, rd_a[0]); end
        checks++; if (busy_a !== 1'b1) begin errors++; $display("FAIL wr_busy got %b want 1", busy_a); end
        wen_a[0] = 1'b1;
        #3;
        checks++; if (gnt_a !== 4'b0001) begin errors++; $display("FAIL rd_gnt got %b want 0001", gnt_a); end
        tick;
        checks++; if (rv_a !== 4'b0001 || rd_a[0] !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_data got rv %b data %h want 0001 deadbeef", rv_a, rd_a[0]); end
        idle_a;
        tick;
        checks++; if (rv_a !== 4'b0000 || busy_a !== 1'b0) begin errors++; $display("FAIL rd_idle got rv %b busy %b want 0000 0", rv_a, busy_a); end
    endtask

    task automatic test_partial_write;
        req_a[0] = 1'b1; add_a[0] = 32'h10; wen_a[0] = 1'b0; be_a[0] = 4'b0101; data_a[0] = 32'h11223344;
        tick;
        wen_a[0] = 1'b1;
        tick;
        checks++; if (rv_a[0] !== 1'b1 || rd_a[0] !== 32'hDE22BE44) begin errors++; $display("FAIL partial_wr got %h want de22be44", rd_a[0]); end
        idle_a;
        tick;
    endtask

    task automatic test_round_robin;
        logic [3:0] exp;
        rst_ni = 1'b0;
        #1;
        rst_ni = 1'b1;
        tick;
        req_a = 4'b1111; wen_a = 4'b1111;
        for (int p = 0; p < 4; p++) add_a[p] = 32'h10;
        for (int c = 0; c < 8; c++) begin
            exp = 4'b0001 << (c % 4);
            #3;
            checks++; if (gnt_a !== exp) begin errors++; $display("FAIL rr_gnt cycle %0d got %b want %b", c, gnt_a, exp); end
            tick;
            checks++; if (rv_a !== exp) begin errors++; $display("FAIL rr_rvalid cycle %0d got %b want %b", c, rv_a, exp); end
            checks++; if (rd_a[c % 4] !== 32'hDE22BE44 || rd_a[(c + 1) % 4] !== 32'h0) begin
                errors++; $display("FAIL rr_rdata cycle %0d got %h/%h want de22be44/0", c, rd_a[c % 4], rd_a[(c + 1) % 4]);
            end
        end
        idle_a;
        tick;
    endtask

    task automatic test_wrap_back_to_back;
        req_a[2] = 1'b1; add_a[2] = 32'h1000; wen_a[2] = 1'b0; be_a[2] = 4'hF; data_a[2] = 32'hCAFEF00D;
        #3;
        checks++; if (gnt_a !== 4'b0100) begin errors++; $display("FAIL wrap_wr_gnt got %b want 0100", gnt_a); end
        tick;
        checks++; if (rv_a !== 4'b0100 || rd_a[2] !== 32'h0) begin errors++; $display("FAIL wrap_wr_rsp got rv %b data %h want 0100 0", rv_a, rd_a[2]); end
        idle_a;
        req_a[3] = 1'b1; add_a[3] = 32'h0; wen_a[3] = 1'b1;
        #3;
        checks++; if (gnt_a !== 4'b1000) begin errors++; $display("FAIL wrap_rd_gnt got %b want 1000", gnt_a); end
        tick;
        checks++; if (rv_a !== 4'b1000 || rd_a[3] !== 32'hCAFEF00D) begin errors++; $display("FAIL wrap_rd_data got rv %b data %h want 1000 cafef00d", rv_a, rd_a[3]); end
        idle_a;
        tick;
    endtask

    task automatic test_clear_and_reset;
        req_a[1] = 1'b1; add_a[1] = 32'h10; wen_a[1] = 1'b1;
        #3;
        checks++; if (gnt_a !== 4'b0010) begin errors++; $display("FAIL clr_rd_gnt got %b want 0010", gnt_a); end
        tick;
        clear_a = 1'b1;
        req_a = 4'b1111; wen_a = 4'b1111;
        for (int p = 0; p < 4; p++) add_a[p] = 32'h10;
        #1;
        checks++; if (rv_a !== 4'b0000 || busy_a !== 1'b0) begin errors++; $display("FAIL clr_drop got rv %b busy %b want 0000 0", rv_a, busy_a); end
        checks++; if (gnt_a !== 4'b0000) begin errors++; $display("FAIL clr_gnt got %b want 0000", gnt_a); end
        #2;
        tick;
        clear_a = 1'b0;
        checks++; if (rv_a !== 4'b0000) begin errors++; $display("FAIL clr_next_rvalid got %b want 0000", rv_a); end
        #3;
        checks++; if (gnt_a !== 4'b0001) begin errors++; $display("FAIL clr_ptr got %b want 0001", gnt_a); end
        tick;
        checks++; if (rv_a !== 4'b0001) begin errors++; $display("FAIL burst_rvalid got %b want 0001", rv_a); end
        #1;
        rst_ni = 1'b0;
        #1;
        checks++; if (gnt_a !== 4'b0000 || rv_a !== 4'b0000 || busy_a !== 1'b0 || rd_a[0] !== 32'h0) begin
            errors++; $display("FAIL async_reset got gnt %b rv %b busy %b data %h want all 0", gnt_a, rv_a, busy_a, rd_a[0]);
        end
        tick;
        rst_ni = 1'b1;
        #3;
        checks++; if (gnt_a !== 4'b0001) begin errors++; $display("FAIL reset_ptr got %b want 0001", gnt_a); end
        tick;
        checks++; if (rv_a !== 4'b0001) begin errors++; $display("FAIL reset_resume got %b want 0001", rv_a); end
        idle_a;
        tick;
    endtask

    task automatic b_xfer(input int p, input logic [31:0] a, input logic w, input logic [31:0] d,
                          output logic ok, output logic rv, output logic [31:0] rd);
        req_b[p] = 1'b1; add_b[p] = a; wen_b[p] = w; data_b[p] = d; be_b[p] = 4'hF;
        ok = 1'b0; rv = 1'b0; rd = 32'h0;
        for (int k = 0; k < 64 && !ok; k++) begin
            #3;
            if (gnt_b[p] === 1'b1) ok = 1'b1;
            tick;
        end
        if (ok) begin
            rv = rv_b[p];
            rd = rd_b[p];
        end
        req_b[p] = 1'b0;
    endtask

    task automatic test_stall_stream;
        logic ok, rv;
        logic [31:0] rd, exp;
        logic [7:0] iv;
        for (int i = 0; i < 256; i++) begin
            iv = 8'(i);
            exp = {iv, ~iv, iv ^ 8'h5A, 8'hC3};
            b_xfer(1, 32'h2000 + 32'(i * 4), 1'b0, exp, ok, rv, rd);
            checks++; if (!ok || rv !== 1'b1 || rd !== 32'h0) begin
                errors++; $display("FAIL stall_wr word %0d got ok %b rv %b data %h want 1 1 0", i, ok, rv, rd);
            end
        end
        for (int i = 0; i < 256; i++) begin
            iv = 8'(i);
            exp = {iv, ~iv, iv ^ 8'h5A, 8'hC3};
            b_xfer(2, 32'h2000 + 32'(i * 4), 1'b1, 32'h0, ok, rv, rd);
            checks++; if (!ok || rv !== 1'b1 || rd !== exp) begin
                errors++; $display("FAIL stall_rd word %0d got ok %b rv %b data %h want 1 1 %h", i, ok, rv, rd, exp);
            end
        end
        tick;
        checks++; if (gnt_viol != 0) begin errors++; $display("FAIL gnt_without_req got %0d want 0", gnt_viol); end
        checks++; if (rv_viol != 0) begin errors++; $display("FAIL rvalid_without_gnt got %0d want 0", rv_viol); end
        checks++; if (stall_cnt == 0) begin errors++; $display("FAIL stall_seen got %0d want >0", stall_cnt); end
    endtask

    initial begin
        rst_ni = 1'b1;
        clear_a = 1'b0;
        idle_a;
        req_b = 4'b0000; wen_b = 4'b0000; add_b = '0; data_b = '0; be_b = '0;
        #2;
        test_reset;
        test_write_read;
        test_partial_write;
        test_round_robin;
        test_wrap_back_to_back;
        test_clear_and_reset;
        test_stall_stream;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
